// File: rtl/joypad_array.sv
// rtl/joypad_array.sv - multi-pad controller conditioner: sync, analog-to-dpad, SOCD, autofire, merge
module joypad_array #(
    parameter int         NUM_PADS     = 2,
    parameter logic [7:0] DEADZONE     = 8'h10,
    parameter logic [7:0] HYST         = 8'h08,
    parameter int         AF_HALF      = 4,
    parameter bit         SOCD_NEUTRAL = 1'b1
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic [32*NUM_PADS-1:0]  cont_key,
    input  logic [32*NUM_PADS-1:0]  cont_joy,
    input  logic                    frame_tick,
    input  logic [15:0]             af_mask,
    input  logic [1:0]              m_mode,
    input  logic [1:0]              active_pl,
    output logic [16*NUM_PADS-1:0]  pad_btn,
    output logic [4*NUM_PADS-1:0]   pad_type,
    output logic [NUM_PADS-1:0]     pad_chg,
    output logic [15:0]             m_btn
);

    localparam logic [7:0] LO_SET = 8'h80 - DEADZONE;
    localparam logic [7:0] LO_CLR = 8'h80 - DEADZONE + HYST;
    localparam logic [7:0] HI_SET = 8'h80 + DEADZONE;
    localparam logic [7:0] HI_CLR = 8'h80 + DEADZONE - HYST;
    localparam logic [7:0] AF_LAST = 8'(AF_HALF - 1);

    logic unused_af;
    assign unused_af = ^af_mask[3:0];

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        logic [18:0] key_s1_q, key_s2_q;
        logic [15:0] joy_s1_q, joy_s2_q;
        logic [3:0]  flag_q, flag_d;
        logic [7:0]  cnt_q, cnt_d;
        logic        phase_q, phase_d;
        logic [15:0] btn_q, btn_d, prev_q;
        logic [2:0]  type_q;
        logic        chg_q;
        logic [3:0]  dir;
        logic [15:0] raw;
        logic [7:0]  x, y;
        logic        held;
        logic        unused_key;

        assign unused_key = ^cont_key[32*p+16 +: 13] ^ ^cont_joy[32*p+16 +: 16];

        always_comb begin
            x       = joy_s2_q[7:0];
            y       = joy_s2_q[15:8];
            flag_d  = flag_q;
            cnt_d   = cnt_q;
            phase_d = phase_q;
            // flag order matches the bitmap: up, down, left, right
            if (key_s2_q[18:16] == 3'd0) begin
                flag_d = 4'b0000;
            end else begin
                if (y < LO_SET) flag_d[0] = 1'b1; else if (y >= LO_CLR) flag_d[0] = 1'b0;
                if (y > HI_SET) flag_d[1] = 1'b1; else if (y <= HI_CLR) flag_d[1] = 1'b0;
                if (x < LO_SET) flag_d[2] = 1'b1; else if (x >= LO_CLR) flag_d[2] = 1'b0;
                if (x > HI_SET) flag_d[3] = 1'b1; else if (x <= HI_CLR) flag_d[3] = 1'b0;
            end
            dir = key_s2_q[3:0] | flag_d;
            if (SOCD_NEUTRAL) begin
                if (dir[0] && dir[1]) dir[1:0] = 2'b00;
                if (dir[2] && dir[3]) dir[3:2] = 2'b00;
            end
            raw  = {key_s2_q[15:4], dir};
            held = |(raw[15:4] & af_mask[15:4]);
            // idle pads park at phase 1 so a fresh press is visible at once
            if (!held) begin
                cnt_d   = 8'd0;
                phase_d = 1'b1;
            end else if (frame_tick) begin
                if (cnt_q == AF_LAST) begin
                    cnt_d   = 8'd0;
                    phase_d = ~phase_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            btn_d = raw & {{12{phase_q}} | ~af_mask[15:4], 4'hF};
        end

        always_ff @(posedge clk_sys or posedge reset) begin
            if (reset) begin
                key_s1_q <= '0;
                key_s2_q <= '0;
                joy_s1_q <= '0;
                joy_s2_q <= '0;
                flag_q   <= '0;
                cnt_q    <= '0;
                phase_q  <= 1'b1;
                btn_q    <= '0;
                prev_q   <= '0;
                type_q   <= '0;
                chg_q    <= 1'b0;
            end else begin
                key_s1_q <= {cont_key[32*p+29 +: 3], cont_key[32*p +: 16]};
                key_s2_q <= key_s1_q;
                joy_s1_q <= cont_joy[32*p +: 16];
                joy_s2_q <= joy_s1_q;
                flag_q   <= flag_d;
                cnt_q    <= cnt_d;
                phase_q  <= phase_d;
                btn_q    <= btn_d;
                type_q   <= key_s2_q[18:16];
                prev_q   <= btn_q;
                chg_q    <= (btn_q != prev_q);
            end
        end

        assign pad_btn[16*p +: 16] = btn_q;
        assign pad_type[4*p +: 4]  = {1'b0, type_q};
        assign pad_chg[p]          = chg_q;
    end

    logic [15:0] m_btn_d, m_or, m_sel;

    always_comb begin
        m_or  = '0;
        m_sel = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            m_or = m_or | pad_btn[16*p +: 16];
            if (active_pl == 2'(p)) m_sel = pad_btn[16*p +: 16];
        end
        case (m_mode)
            2'd0:    m_btn_d = pad_btn[15:0];
            2'd1:    m_btn_d = m_or;
            2'd2:    m_btn_d = m_sel;
            default: m_btn_d = '0;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) m_btn <= '0;
        else       m_btn <= m_btn_d;
    end

endmodule

// File: tb/tb_joypad_array.sv
// tb/tb_joypad_array.sv - directed vector bench for joypad_array
module tb_joypad_array;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] key = '0, joy = {2{32'h0000_8080}};
    logic        tick = 1'b0;
    logic [15:0] af = '0;
    logic [1:0]  mode = '0, apl = '0;
    logic [31:0] btn;
    logic [7:0]  ptype;
    logic [1:0]  chg;
    logic [15:0] mb;

    logic [31:0] key2 = '0, joy2 = 32'h0000_8080;
    logic [15:0] btn2;
    logic [3:0]  ptype2;
    logic [0:0]  chg2;
    logic [15:0] mb2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    joypad_array u_dut (
        .clk_sys(clk), .reset(rst), .cont_key(key), .cont_joy(joy),
        .frame_tick(tick), .af_mask(af), .m_mode(mode), .active_pl(apl),
        .pad_btn(btn), .pad_type(ptype), .pad_chg(chg), .m_btn(mb)
    );

    joypad_array #(.NUM_PADS(1), .SOCD_NEUTRAL(1'b0)) u_nosocd (
        .clk_sys(clk), .reset(rst), .cont_key(key2), .cont_joy(joy2),
        .frame_tick(tick), .af_mask(af), .m_mode(mode), .active_pl(apl),
        .pad_btn(btn2), .pad_type(ptype2), .pad_chg(chg2), .m_btn(mb2)
    );

    typedef struct {
        logic [31:0] key0, joy0, key1, joy1;
        logic [1:0]  mode, apl;
        logic [15:0] af;
        logic [31:0] exp_btn;
        logic [7:0]  exp_type;
        logic [15:0] exp_m;
    } vec_t;

    vec_t vt [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame();
        tick = 1'b1;
        edges(1);
        tick = 1'b0;
        edges(9);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        vt[0]  = '{32'h2000_0000, 32'h8080, 0, 32'h8080, 0, 0, 0, 32'h0000_0000, 8'h01, 16'h0000};
        vt[1]  = '{32'h2000_0000, 32'h806F, 0, 32'h8080, 0, 0, 0, 32'h0000_0004, 8'h01, 16'h0004};
        vt[2]  = '{32'h2000_0000, 32'h8075, 0, 32'h8080, 0, 0, 0, 32'h0000_0004, 8'h01, 16'h0004};
        vt[3]  = '{32'h2000_0000, 32'h8078, 0, 32'h8080, 0, 0, 0, 32'h0000_0000, 8'h01, 16'h0000};
        vt[4]  = '{32'h2000_0000, 32'h808F, 0, 32'h8080, 0, 0, 0, 32'h0000_0000, 8'h01, 16'h0000};
        vt[5]  = '{32'h2000_0000, 32'h8091, 0, 32'h8080, 0, 0, 0, 32'h0000_0008, 8'h01, 16'h0008};
        vt[6]  = '{32'h2000_0000, 32'h8089, 0, 32'h8080, 0, 0, 0, 32'h0000_0008, 8'h01, 16'h0008};
        vt[7]  = '{32'h2000_0000, 32'h8088, 0, 32'h8080, 0, 0, 0, 32'h0000_0000, 8'h01, 16'h0000};
        vt[8]  = '{32'h2000_0000, 32'h6080, 0, 32'h8080, 0, 0, 0, 32'h0000_0001, 8'h01, 16'h0001};
        vt[9]  = '{32'h0000_0000, 32'h0000, 0, 32'h8080, 0, 0, 0, 32'h0000_0000, 8'h00, 16'h0000};
        vt[10] = '{32'h2000_0001, 32'hFF80, 0, 32'h8080, 0, 0, 0, 32'h0000_0000, 8'h01, 16'h0000};
        vt[11] = '{32'h2000_0020, 32'h8080, 32'h2000_0040, 32'h8080, 1, 0, 0, 32'h0040_0020, 8'h11, 16'h0060};
        vt[12] = '{32'h2000_0020, 32'h8080, 32'h2000_0040, 32'h8080, 2, 1, 0, 32'h0040_0020, 8'h11, 16'h0040};
        vt[13] = '{32'h2000_0020, 32'h8080, 32'h2000_0040, 32'h8080, 2, 3, 0, 32'h0040_0020, 8'h11, 16'h0000};
        vt[14] = '{32'h2000_0020, 32'h8080, 32'h2000_0040, 32'h8080, 2, 0, 0, 32'h0040_0020, 8'h11, 16'h0020};
        vt[15] = '{32'h2000_0020, 32'h8080, 32'h2000_0040, 32'h8080, 3, 0, 0, 32'h0040_0020, 8'h11, 16'h0000};
        vt[16] = '{32'h2000_000C, 32'h8080, 32'h2000_0040, 32'h8080, 1, 0, 0, 32'h0040_0000, 8'h11, 16'h0040};
        vt[17] = '{32'h2000_0010, 32'h8080, 32'h2000_0040, 32'h8080, 1, 0, 16'h0010, 32'h0040_0010, 8'h11, 16'h0050};
        vt[18] = '{32'h2000_0001, 32'h8080, 32'h2000_0040, 32'h8080, 0, 0, 16'h000F, 32'h0040_0001, 8'h11, 16'h0001};

        #1;
        chk("reset_btn", btn, 0);
        chk("reset_chg", {30'd0, chg}, 0);
        chk("reset_m", {16'd0, mb}, 0);
        edges(2);
        rst = 1'b0;
        edges(4);

        for (int i = 0; i < 19; i++) begin
            key  = {vt[i].key1, vt[i].key0};
            joy  = {vt[i].joy1, vt[i].joy0};
            mode = vt[i].mode;
            apl  = vt[i].apl;
            af   = vt[i].af;
            edges(6);
            chk($sformatf("v%0d_btn", i), btn, vt[i].exp_btn);
            chk($sformatf("v%0d_type", i), {24'd0, ptype}, {24'd0, vt[i].exp_type});
            chk($sformatf("v%0d_m", i), {16'd0, mb}, {16'd0, vt[i].exp_m});
        end

        key2 = 32'h2000_0001;
        joy2 = 32'h0000_FF80;
        edges(6);
        chk("nosocd_ud", {16'd0, btn2}, 32'h0003);

        key = '0; joy = {2{32'h0000_8080}}; mode = 0; apl = 0; af = '0;
        edges(8);
        key[15:0] = 16'h0010;
        for (int e = 1; e <= 5; e++) begin
            edges(1);
            chk($sformatf("lat_btn_e%0d", e), {16'd0, btn[15:0]}, (e >= 3) ? 32'h0010 : 32'h0);
            chk($sformatf("lat_chg_e%0d", e), {31'd0, chg[0]}, (e == 4) ? 32'h1 : 32'h0);
            chk($sformatf("lat_m_e%0d", e), {16'd0, mb}, (e >= 4) ? 32'h0010 : 32'h0);
        end

        af = 16'h0010;
        edges(4);
        chk("af_start", {31'd0, btn[4]}, 1);
        for (int n = 1; n <= 10; n++) begin
            frame();
            chk($sformatf("af_tick%0d", n), {31'd0, btn[4]}, ((n / 4) % 2 == 0) ? 32'h1 : 32'h0);
        end
        key[15:0] = 16'h0000;
        edges(6);
        chk("af_release", {31'd0, btn[4]}, 0);
        key[15:0] = 16'h0010;
        edges(3);
        chk("af_repress", {31'd0, btn[4]}, 1);

        for (int n = 0; n < 5; n++) frame();
        chk("af_pre_reset", {31'd0, btn[4]}, 0);
        rst = 1'b1;
        #1;
        chk("rst_async_btn", btn, 0);
        chk("rst_async_m", {16'd0, mb}, 0);
        edges(1);
        rst = 1'b0;
        pulses = 0;
        for (int e = 1; e <= 10; e++) begin
            edges(1);
            if (chg[0]) pulses++;
            if (e <= 3)
                chk($sformatf("rst_btn_e%0d", e), {31'd0, btn[4]}, (e == 3) ? 32'h1 : 32'h0);
        end
        chk("rst_chg_pulses", pulses, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/joypad_array.md
JOYPAD_ARRAY -- requirements
Module: joypad_array

Interface
REQ-001 The block SHALL have parameter NUM_PADS, default 2, meaning controller channels instantiated (legal 1..4).
REQ-002 The block SHALL have parameter DEADZONE, default 8'h10, meaning analog assert distance from centre 8'h80.
REQ-003 The block SHALL have parameter HYST, default 8'h08, meaning release threshold offset toward centre (HYST < DEADZONE).
REQ-004 The block SHALL have parameter AF_HALF, default 4, meaning autofire half-period in frame_tick pulses (legal 1..255).
REQ-005 The block SHALL have parameter SOCD_NEUTRAL, default 1, meaning opposing directions cancel when 1.
REQ-006 The block SHALL have port clk_sys, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port cont_key, input, 32*NUM_PADS bits: per pad, [15:0] buttons (Pocket bitmap) and [31:29] type.
REQ-009 The block SHALL have port cont_joy, input, 32*NUM_PADS bits: per pad, [7:0] lstick_x and [15:8] lstick_y, unsigned.
REQ-010 The block SHALL have port frame_tick, input, 1 bit: one-cycle pulse per video frame.
REQ-011 The block SHALL have port af_mask, input, 16 bits: buttons subject to autofire, bits [15:4] only.
REQ-012 The block SHALL have port m_mode, input, 2 bits: merged-output mode.
REQ-013 The block SHALL have port active_pl, input, 2 bits: pad selected when m_mode=2.
REQ-014 The block SHALL have port pad_btn, output, 16*NUM_PADS bits: processed buttons; [3:0] are directions.
REQ-015 The block SHALL have port pad_type, output, 4*NUM_PADS bits: {1'b0, type}.
REQ-016 The block SHALL have port pad_chg, output, NUM_PADS bits: one-cycle change strobe per pad.
REQ-017 The block SHALL have port m_btn, output, 16 bits: merged arcade buttons in the same bitmap.

Function
REQ-018 cont_key and cont_joy SHALL pass through a two-flop synchroniser before any use.
REQ-019 pad_btn and pad_type SHALL be registered: an input change SHALL appear at the outputs exactly 3 clk_sys edges later when the autofire phase is 1.
REQ-020 Analog flags SHALL be evaluated only when type!=0; when type=0 the flags SHALL be cleared and held at 0.
REQ-021 Left SHALL set when x < 8'h80-DEADZONE and clear when x >= 8'h80-DEADZONE+HYST; right SHALL set when x > 8'h80+DEADZONE and clear when x <= 8'h80+DEADZONE-HYST; up and down SHALL do the same on y; in the band between set and clear thresholds each flag SHALL hold its state.
REQ-022 Each direction bit SHALL be the dpad bit OR the analog flag.
REQ-023 With SOCD_NEUTRAL=1, up&down both 1 SHALL clear both, and left&right both 1 SHALL clear both.
REQ-024 Each pad SHALL have an 8-bit autofire counter and a phase bit; on frame_tick the counter SHALL increment, and when counter=AF_HALF-1 it SHALL wrap to 0 and toggle phase.
REQ-025 When no af_mask button is held on a pad, that pad's counter SHALL be forced to 0 and phase to 1, so the first press is output immediately.
REQ-026 Output button bit b SHALL equal raw[b] & (phase | ~af_mask[b]); af_mask[3:0] SHALL be ignored.
REQ-027 pad_chg[p] SHALL pulse for one cycle in the cycle after registered pad_btn[p] differs from its previous value.
REQ-028 m_btn SHALL be registered from pad_btn, latency +1 cycle: m_mode 0 = pad 0; 1 = bitwise OR of all pads; 2 = pad[active_pl], with 0 when active_pl >= NUM_PADS; 3 = 0.
REQ-029 m_mode and active_pl SHALL take effect on the next edge with no glitch cycle.
REQ-030 Unused pads (index >= NUM_PADS) SHALL NOT exist in any port width.

Reset
REQ-031 While reset=1, all synchroniser, hysteresis and output registers SHALL be 0, counters 0 and phase 1; outputs SHALL go to 0 asynchronously.
REQ-032 Reset asserted mid-autofire SHALL restart the cadence; the first edge after release SHALL sample the inputs fresh, with no stale strobe on pad_chg.

Verification
REQ-033 Scenario: pad0 key=0x0010 applied at edge 0 -> pad_btn[15:0]=0x0010 after edge 3; pad_chg[0]=1 for one cycle after edge 4; m_btn=0x0010 (m_mode=0) after edge 4.
REQ-034 Scenario: type=1, x swept 80->6F->75->78 -> left=0,1,1,0; x=8F -> right=0; x=91 -> right=1; x=89 -> right=1; x=88 -> right=0.
REQ-035 Scenario: dpad up=1 with y=0xFF, SOCD_NEUTRAL=1 -> pad_btn[1:0]=00; with SOCD_NEUTRAL=0 -> 11.
REQ-036 Scenario: af_mask=0x0010, A held, frame_tick every 10 cycles, AF_HALF=4 -> bit4 shows 1 for 4 ticks, then 0 for 4 ticks, repeating; release then press -> immediately 1.
REQ-037 Scenario: NUM_PADS=2, m_mode=1, pad0=0x0020, pad1=0x0040 -> m_btn=0x0060; m_mode=2, active_pl=1 -> 0x0040; active_pl=3 -> 0x0000.
REQ-038 Scenario: reset pulsed for 1 cycle mid-autofire with A held -> outputs 0 during reset; A=1 3 edges after release; pad_chg pulses once.
